coin_sprite_animator: RTL and testbench

- Upstream address/animation stage for the 20x20 four-frame coin-spin sprite ROMs, which are combinational, 9-bit address, 24-bit colour out.
- Each cycle it maps the VGA draw coordinate to a ROM address and selects the active spin frame.
- It registers the returned colour and flags opaque coin pixels for the colour mapper.
- It owns the coin's life cycle: hidden, spinning, and the collected "pop" rise.

---
 rtl/coin_sprite_animator.sv | 197 +++++++++++++++++++
 tb/tb_coin_sprite_animator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_sprite_animator.sv
// Coin sprite address/animation stage: maps DrawX/DrawY to a 20x20 ROM address, picks the spin frame,
// registers the ROM colour and runs the HIDDEN/SPINNING/POPPING life cycle. Option: COIN_SPIN_PINGPONG_EN.
module coin_sprite_animator #(
    parameter int          SPRITE_W        = 20,
    parameter int          TICKS_PER_STEP  = 8,
    parameter int          POP_TICKS       = 16,
    parameter int          POP_RISE        = 2,
    parameter logic [23:0] TRANSPARENT_KEY = 24'h800080
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        spawn,
    input  logic        collect,
    input  logic [9:0]  spawn_x,
    input  logic [9:0]  spawn_y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [23:0] rom_color,
    output logic [8:0]  rom_address,
    output logic [1:0]  frame_sel,
    output logic        coin_on,
    output logic [23:0] coin_color,
    output logic [1:0]  coin_state
);

    typedef enum logic [1:0] {HIDDEN = 2'd0, SPINNING = 2'd1, POPPING = 2'd2} state_t;

    localparam int STEP_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int POP_W  = $clog2(POP_TICKS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TICKS_PER_STEP - 1);
    localparam logic [POP_W-1:0]  POP_LAST  = POP_W'(POP_TICKS - 1);
    localparam logic [9:0]        SIZE10    = 10'(SPRITE_W);
    localparam logic [8:0]        SIZE9     = 9'(SPRITE_W);
    localparam logic [9:0]        RISE10    = 10'(POP_RISE);

    state_t             state_q, state_d;
    logic [1:0]         frame_q, frame_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [POP_W-1:0]   pop_q, pop_d;
    logic [9:0]         pos_x_q, pos_x_d;
    logic [9:0]         pos_y_q, pos_y_d;
    logic [8:0]         addr_q, addr_d;
    logic               inside_q, inside_d;
    logic               on_q, on_d;
    logic [23:0]        color_q, color_d;
    logic [1:0]         adv_frame;

`ifdef COIN_SPIN_PINGPONG_EN
    logic dir_down_q, dir_down_d;
    logic adv_dir_down;

    // Bounce at the ends of the 0..3 range instead of wrapping.
    always_comb begin
        adv_dir_down = dir_down_q;
        if (!dir_down_q) begin
            if (frame_q == 2'd3) begin
                adv_frame    = 2'd2;
                adv_dir_down = 1'b1;
            end else begin
                adv_frame = frame_q + 2'd1;
            end
        end else if (frame_q == 2'd0) begin
            adv_frame    = 2'd1;
            adv_dir_down = 1'b0;
        end else begin
            adv_frame = frame_q - 2'd1;
        end
    end
`else
    assign adv_frame = frame_q + 2'd1;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= HIDDEN;
            frame_q    <= 2'd0;
            step_q     <= '0;
            pop_q      <= '0;
            pos_x_q    <= 10'd0;
            pos_y_q    <= 10'd0;
            addr_q     <= 9'd0;
            inside_q   <= 1'b0;
            on_q       <= 1'b0;
            color_q    <= 24'd0;
`ifdef COIN_SPIN_PINGPONG_EN
            dir_down_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            step_q     <= step_d;
            pop_q      <= pop_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            addr_q     <= addr_d;
            inside_q   <= inside_d;
            on_q       <= on_d;
            color_q    <= color_d;
`ifdef COIN_SPIN_PINGPONG_EN
            dir_down_q <= dir_down_d;
`endif
        end
    end

    // Next-state: life cycle, animation counters and the two pixel stages
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        step_d  = step_q;
        pop_d   = pop_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
`ifdef COIN_SPIN_PINGPONG_EN
        dir_down_d = dir_down_q;
`endif
        unique case (state_q)
            HIDDEN: begin
                if (spawn) begin
                    state_d = SPINNING;
                    pos_x_d = spawn_x;
                    pos_y_d = spawn_y;
                    frame_d = 2'd0;
                    step_d  = '0;
`ifdef COIN_SPIN_PINGPONG_EN
                    dir_down_d = 1'b0;
`endif
                end
            end
            SPINNING: begin
                // A pending collect or respawn takes the cycle; a coincident tick is dropped.
                if (collect) begin
                    state_d = POPPING;
                    pop_d   = '0;
                end else if (spawn) begin
                    pos_x_d = spawn_x;
                    pos_y_d = spawn_y;
                    frame_d = 2'd0;
                    step_d  = '0;
`ifdef COIN_SPIN_PINGPONG_EN
                    dir_down_d = 1'b0;
`endif
                end else if (frame_tick) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        frame_d = adv_frame;
`ifdef COIN_SPIN_PINGPONG_EN
                        dir_down_d = adv_dir_down;
`endif
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            POPPING: begin
                if (frame_tick) begin
                    frame_d = adv_frame;
`ifdef COIN_SPIN_PINGPONG_EN
                    dir_down_d = adv_dir_down;
`endif
                    pos_y_d = (pos_y_q < RISE10) ? 10'd0 : pos_y_q - RISE10;
                    if (pop_q == POP_LAST) begin
                        state_d = HIDDEN;
                        pop_d   = '0;
                    end else begin
                        pop_d = pop_q + 1'b1;
                    end
                end
            end
            default: state_d = HIDDEN;
        endcase
    end

    // Pixel stage 1 (box test + address) and stage 2 (colour capture + key test)
    logic [9:0] dx, dy;
    always_comb begin
        dx       = DrawX - pos_x_q;
        dy       = DrawY - pos_y_q;
        inside_d = (state_q != HIDDEN) && (DrawX >= pos_x_q) && (DrawY >= pos_y_q)
                   && (dx < SIZE10) && (dy < SIZE10);
        // Inside the box dx/dy are below SPRITE_W, which fits in 5 bits for any legal size.
        addr_d   = inside_d ? ({4'd0, dy[4:0]} * SIZE9 + {4'd0, dx[4:0]}) : 9'd0;
        color_d  = rom_color;
        on_d     = inside_q && (rom_color != TRANSPARENT_KEY);
    end

    // Outputs
    always_comb begin
        rom_address = addr_q;
        frame_sel   = frame_q;
        coin_on     = on_q;
        coin_color  = color_q;
        coin_state  = state_q;
    end

endmodule

// File: tb/tb_coin_sprite_animator.sv
// Scoreboard bench for coin_sprite_animator: stimulus pushes timed expectations, a negedge monitor
// pops and compares them. Define COIN_SPIN_PINGPONG_EN for both DUT and bench to test the bounce sequence.
module tb_coin_sprite_animator;

  logic        clk;
  logic        reset_n;
  logic        frame_tick;
  logic        spawn;
  logic        collect;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [23:0] rom_color;
  logic [8:0]  rom_address;
  logic [1:0]  frame_sel;
  logic        coin_on;
  logic [23:0] coin_color;
  logic [1:0]  coin_state;

  coin_sprite_animator dut (
    .Clk         (clk),
    .Reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .spawn       (spawn),
    .collect     (collect),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .rom_color   (rom_color),
    .rom_address (rom_address),
    .frame_sel   (frame_sel),
    .coin_on     (coin_on),
    .coin_color  (coin_color),
    .coin_state  (coin_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  localparam int SIG_ADDR  = 0;
  localparam int SIG_FRAME = 1;
  localparam int SIG_ON    = 2;
  localparam int SIG_COLOR = 3;
  localparam int SIG_STATE = 4;

  typedef struct {
    int          due;
    int          sig;
    string       name;
    logic [23:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void expect_at(int sig, string name, logic [23:0] val, int delay);
    exp_t e;
    e.due  = cyc + delay;
    e.sig  = sig;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  function automatic logic [23:0] dut_value(int sig);
    case (sig)
      SIG_ADDR:  return {15'd0, rom_address};
      SIG_FRAME: return {22'd0, frame_sel};
      SIG_ON:    return {23'd0, coin_on};
      SIG_COLOR: return coin_color;
      default:   return {22'd0, coin_state};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        logic [23:0] act;
        act = dut_value(exp_q[i].sig);
        checks++;
        if (exp_q[i].due < cyc || act !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s got %0h expected %0h (cycle %0d, due %0d)",
                   exp_q[i].name, act, exp_q[i].val, cyc, exp_q[i].due);
        end
        exp_q.delete(i);
      end
    end
  end

  // ---------------- reference for the spin sequence ----------------
  function automatic logic [1:0] exp_frame(int advances);
`ifdef COIN_SPIN_PINGPONG_EN
    logic [1:0] seq6 [6];
    seq6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    return seq6[advances % 6];
`else
    return 2'(advances % 4);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pixel, then return rom_color for the registered address one cycle later.
  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic [23:0] color,
                       input logic [8:0] exp_addr, input logic exp_on, input string tag);
    draw_x = x;
    draw_y = y;
    expect_at(SIG_ADDR, {tag, ".addr"}, {15'd0, exp_addr}, 1);
    step();
    rom_color = color;
    expect_at(SIG_ON, {tag, ".on"}, {23'd0, exp_on}, 1);
    expect_at(SIG_COLOR, {tag, ".color"}, color, 1);
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic do_spawn(input logic [9:0] x, input logic [9:0] y, input logic with_collect,
                          input logic [1:0] exp_state, input string tag);
    spawn   = 1'b1;
    collect = with_collect;
    spawn_x = x;
    spawn_y = y;
    expect_at(SIG_STATE, {tag, ".state"}, {22'd0, exp_state}, 1);
    step();
    spawn   = 1'b0;
    collect = 1'b0;
  endtask

  task automatic do_collect(input logic [1:0] exp_state, input string tag);
    collect = 1'b1;
    expect_at(SIG_STATE, {tag, ".state"}, {22'd0, exp_state}, 1);
    step();
    collect = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    spawn      = 1'b1;
    collect    = 1'b0;
    spawn_x    = 10'd100;
    spawn_y    = 10'd50;
    draw_x     = 10'd105;
    draw_y     = 10'd55;
    rom_color  = 24'hF83800;
    repeat (3) step();

    // Reset state with spawn held high
    expect_at(SIG_STATE, "rst.state", 24'd0, 0);
    expect_at(SIG_ADDR,  "rst.addr",  24'd0, 0);
    expect_at(SIG_ON,    "rst.on",    24'd0, 0);
    expect_at(SIG_FRAME, "rst.frame", 24'd0, 0);
    expect_at(SIG_COLOR, "rst.color", 24'd0, 0);
    reset_n = 1'b1;
    spawn   = 1'b0;
    expect_at(SIG_STATE, "post_rst.state", 24'd0, 1);
    expect_at(SIG_ON,    "post_rst.on1",   24'd0, 1);
    expect_at(SIG_ON,    "post_rst.on2",   24'd0, 2);
    step();
    step();

    // Address mapping and transparency at (100,50)
    do_spawn(10'd100, 10'd50, 1'b0, 2'd1, "spawn1");
    pixel(10'd107, 10'd53, 24'hF83800, 9'd67,  1'b1, "px_mid");
    pixel(10'd119, 10'd69, 24'h800080, 9'd399, 1'b0, "px_key");
    pixel(10'd119, 10'd69, 24'hF83800, 9'd399, 1'b1, "px_max");
    pixel(10'd100, 10'd50, 24'h123456, 9'd0,   1'b1, "px_origin");
    pixel(10'd120, 10'd53, 24'hF83800, 9'd0,   1'b0, "px_right");
    pixel(10'd99,  10'd53, 24'hF83800, 9'd0,   1'b0, "px_left");
    pixel(10'd107, 10'd49, 24'hF83800, 9'd0,   1'b0, "px_above");
    pixel(10'd107, 10'd70, 24'hF83800, 9'd0,   1'b0, "px_below");

    // Spin cadence: one advance every 8 ticks
    for (int i = 1; i <= 32; i++) begin
      frame_tick = 1'b1;
      expect_at(SIG_FRAME, $sformatf("spin.frame%0d", i), {22'd0, exp_frame(i / 8)}, 1);
      step();
      frame_tick = 1'b0;
      step();
    end

    // Respawn while spinning relatches position and restarts the frame
    tick();
    do_spawn(10'd200, 10'd100, 1'b0, 2'd1, "respawn");
    expect_at(SIG_FRAME, "respawn.frame", 24'd0, 0);
    pixel(10'd205, 10'd101, 24'hF83800, 9'd25, 1'b1, "px_respawn");

    // Collect at pos_y=50 after one spin advance, then pop for 16 ticks
    do_spawn(10'd100, 10'd50, 1'b0, 2'd1, "spawn2");
    repeat (8) tick();
    do_collect(2'd2, "collect");
    expect_at(SIG_FRAME, "collect.frame", {22'd0, exp_frame(1)}, 0);
    for (int i = 1; i <= 16; i++) begin
      frame_tick = 1'b1;
      expect_at(SIG_FRAME, $sformatf("pop.frame%0d", i), {22'd0, exp_frame(1 + i)}, 1);
      expect_at(SIG_STATE, $sformatf("pop.state%0d", i), (i == 16) ? 24'd0 : 24'd2, 1);
      step();
      frame_tick = 1'b0;
      if (i < 16) begin
        pixel(10'd101, 10'(51 - 2 * i), 24'hF83800, 9'd21, 1'b1, $sformatf("pop.y%0d", i));
      end else begin
        pixel(10'd101, 10'd19, 24'hF83800, 9'd0, 1'b0, "pop.hidden");
      end
    end

    // Rise saturates at the top edge
    do_spawn(10'd300, 10'd3, 1'b0, 2'd1, "spawn3");
    do_collect(2'd2, "collect3");
    tick();
    pixel(10'd301, 10'd2, 24'hF83800, 9'd21, 1'b1, "sat.y1");
    tick();
    pixel(10'd301, 10'd1, 24'hF83800, 9'd21, 1'b1, "sat.y0");
    tick();
    pixel(10'd301, 10'd1, 24'hF83800, 9'd21, 1'b1, "sat.hold");
    repeat (12) tick();
    frame_tick = 1'b1;
    expect_at(SIG_STATE, "sat.end", 24'd0, 1);
    step();
    frame_tick = 1'b0;
    step();

    // Simultaneous spawn+collect, and spawn ignored while popping
    do_spawn(10'd40, 10'd60, 1'b1, 2'd1, "both_hidden");
    do_spawn(10'd500, 10'd500, 1'b1, 2'd2, "both_spin");
    pixel(10'd41, 10'd61, 24'h00FF00, 9'd21, 1'b1, "both_spin.pos");
    do_spawn(10'd500, 10'd500, 1'b0, 2'd2, "spawn_in_pop");
    pixel(10'd41, 10'd61, 24'h00FF00, 9'd21, 1'b1, "spawn_in_pop.pos");
    do_collect(2'd2, "collect_in_pop");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
